spatz_issue_scoreboard: RTL
===========================

Name: spatz_issue_scoreboard

Overview:
- Sits between the Spatz decoder and the execution units (VFU, VLSU).
- Allocates a free instruction ID to each decoded vector request and tracks every in-flight instruction in a table.
- Holds back any request with a RAW, WAW or WAR register hazard against in-flight work.
- Routes the issued request to the unit named by ex_unit and frees the ID when that unit responds.

Parameters:
- NrParallelInstr, default 4: in-flight table depth; IDs are 0..NrParallelInstr-1 (spatz_id_t width = clog2).
- NrVregs, default 32: architectural vector registers; register fields are compared on the full 5-bit index.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- spatz_req_i  in  spatz_req_t  decoded request; its id field is ignored
- spatz_req_valid_i  in  1  request valid
- spatz_req_ready_o  out  1  request accepted (issued) this cycle
- spatz_req_o  out  spatz_req_t  issued request with id overwritten by the allocated ID
- vfu_req_valid_o  out  1  issue to VFU (ex_unit==VFU)
- vfu_req_ready_i  in  1  VFU accepts
- vlsu_req_valid_o  out  1  issue to VLSU (ex_unit==LSU)
- vlsu_req_ready_i  in  1  VLSU accepts
- vfu_rsp_valid_i  in  1  VFU completion
- vfu_rsp_i  in  vfu_rsp_t  completion payload; only id is used
- vlsu_rsp_valid_i  in  1  VLSU completion
- vlsu_rsp_id_i  in  spatz_id_t  VLSU completion ID
- busy_o  out  1  any table entry valid
- err_o  out  1  sticky: a response arrived for an ID that is not valid

Behaviour:
- Reset: all table entries invalid; busy_o=0, err_o=0, all valid/ready outputs 0. Reset mid-operation discards all in-flight state; responses arriving after reset for old IDs set err_o.
- Table entry fields: valid, vd, vs1, vs2, use_vd, use_vs1, use_vs2, vd_is_src, ex_unit.
- Hazard between new request N and valid entry E:
  - RAW: (N.use_vs1 && E.use_vd && E.vd==N.vs1), or the same test on vs2, or (N.vd_is_src && E.use_vd && E.vd==N.vd).
  - WAW: N.use_vd && E.use_vd && E.vd==N.vd.
  - WAR: N.use_vd && ((E.use_vs1 && E.vs1==N.vd) || (E.use_vs2 && E.vs2==N.vd) || (E.vd_is_src && E.vd==N.vd)).
  - hazard = OR over all valid entries.
- Allocation: the lowest-index invalid entry; free = at least one invalid entry.
- Issue timing: combinational, zero cycles of latency.
  - can_issue = spatz_req_valid_i && !hazard && free.
  - vfu_req_valid_o = can_issue && ex_unit==VFU; vlsu_req_valid_o = can_issue && ex_unit==LSU.
  - Other ex_unit values: issue with no unit valid; the entry is not recorded and the ID is not consumed.
  - Valid outputs never depend on the downstream ready.
- Fire: the selected valid && ready. spatz_req_ready_o = fire. On fire, the allocated entry is set valid at the next edge.
- Retire: on rsp valid, the entry at rsp id is cleared at the next edge. VFU and VLSU responses in the same cycle retire both entries.
- Simultaneous events:
  - Hazard and free are computed from the registered table only.
  - An entry retiring this cycle still blocks and is not reallocatable until the next cycle.
  - Issue and retire in the same cycle are independent; they never target the same entry because the issued entry was invalid.
- Stability: the table changes only by this request issuing or by retires, so once valid is raised it stays high until fire, provided the input request is held.
- Error: a response to an invalid ID sets err_o (cleared only by reset); the table is unchanged.
- busy_o is registered-state-derived: OR of entry valid bits.

Decomposition:
- spatz_pkg holds:
  - NrParallelInstr, spatz_id_t, spatz_req_t, vfu_rsp_t and the ex_unit enum (existing);
  - a new scoreboard_entry_t struct with the fields above.
- One natural sub-module: spatz_sb_hazard_check, combinational; inputs are the request and the entry array; outputs are the hazard flag, the free flag and the allocated ID.

Test Plan:
- Issue and retire: after reset, VFU add vd=3, vs1=1, vs2=2 with ready=1 → fires the same cycle with id=0, busy_o=1. vfu_rsp id=0 → busy_o=0 on the next cycle.
- RAW stall: issue vd=4. Next request reads vs2=4 → valid outputs stay 0 and ready_o=0 until vfu_rsp id=0. The request then issues one cycle after the retire edge, with id=0 again.
- WAW/WAR: in-flight entry reads vs1=7. A new request writing vd=7 stalls. A request writing vd=8 issues with id=1. Then a request writing vd=8 stalls (WAW).
- Full table: 4 independent instructions get ids 0,1,2,3 and the 5th stalls. vlsu_rsp id=2 → the 5th issues with id=2.
- Backpressure and dual retire: vfu_req_ready_i=0 for 3 cycles → vfu_req_valid_o held at 1 and the table is unchanged. Then VFU and VLSU responses in the same cycle for ids 0 and 1 → both entries are freed.
- Error and reset: vfu_rsp for invalid id=3 → err_o=1 and sticky. Assert rst_ni low mid-operation with 2 entries valid → all outputs return to 0, and the next request gets id=0.

Source files
------------

// File: rtl/spatz_pkg.sv
// spatz_pkg: shared Spatz request, response and scoreboard types
package spatz_pkg;
  localparam int unsigned NrParallelInstr = 4;
  localparam int unsigned NrVregs = 32;
  localparam int unsigned IdWidth = NrParallelInstr > 1 ? $clog2(NrParallelInstr) : 1;
  localparam int unsigned RegWidth = $clog2(NrVregs);
  typedef logic [IdWidth-1:0] spatz_id_t;
  typedef logic [RegWidth-1:0] vreg_t;
  typedef enum logic [1:0] {CON, VFU, LSU, SLD} ex_unit_e;
  typedef struct packed {
    spatz_id_t id;
    ex_unit_e ex_unit;
    vreg_t vd;
    vreg_t vs1;
    vreg_t vs2;
    logic use_vd;
    logic use_vs1;
    logic use_vs2;
    logic vd_is_src;
  } spatz_req_t;
  typedef struct packed {
    spatz_id_t id;
  } vfu_rsp_t;
  typedef struct packed {
    logic valid;
    vreg_t vd;
    vreg_t vs1;
    vreg_t vs2;
    logic use_vd;
    logic use_vs1;
    logic use_vs2;
    logic vd_is_src;
    ex_unit_e ex_unit;
  } scoreboard_entry_t;
  function automatic logic entry_conflicts(spatz_req_t r, scoreboard_entry_t e);
    logic raw, waw, war;
    raw = e.use_vd && ((r.use_vs1 && e.vd == r.vs1) || (r.use_vs2 && e.vd == r.vs2) || (r.vd_is_src && e.vd == r.vd));
    waw = r.use_vd && e.use_vd && e.vd == r.vd;
    war = r.use_vd && ((e.use_vs1 && e.vs1 == r.vd) || (e.use_vs2 && e.vs2 == r.vd) || (e.vd_is_src && e.vd == r.vd));
    return e.valid && (raw || waw || war);
  endfunction
endpackage

// File: rtl/spatz_sb_hazard_check.sv
// spatz_sb_hazard_check: hazard, free-slot and lowest-free-ID search over the in-flight table
module spatz_sb_hazard_check import spatz_pkg::*; (
  input  spatz_req_t                               req_i,
  input  scoreboard_entry_t [NrParallelInstr-1:0]  sb_i,
  output logic                                     hazard_o,
  output logic                                     free_o,
  output spatz_id_t                                id_o
);
  logic unused_fields;
  assign unused_fields = ^{req_i.id, req_i.ex_unit, sb_i};
  // scan every entry: any conflict blocks, first invalid entry is allocated
  always_comb begin
    hazard_o = 1'b0;
    free_o = 1'b0;
    id_o = '0;
    for (int i = 0; i < NrParallelInstr; i++) begin
      hazard_o = hazard_o | entry_conflicts(req_i, sb_i[i]);
      if (!sb_i[i].valid && !free_o) begin
        free_o = 1'b1;
        id_o = spatz_id_t'(i);
      end
    end
  end
endmodule

// File: rtl/spatz_issue_scoreboard.sv
// spatz_issue_scoreboard: allocates IDs, blocks register hazards and routes requests to VFU/VLSU
module spatz_issue_scoreboard import spatz_pkg::*; (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  spatz_req_t spatz_req_i,
  input  logic       spatz_req_valid_i,
  output logic       spatz_req_ready_o,
  output spatz_req_t spatz_req_o,
  output logic       vfu_req_valid_o,
  input  logic       vfu_req_ready_i,
  output logic       vlsu_req_valid_o,
  input  logic       vlsu_req_ready_i,
  input  logic       vfu_rsp_valid_i,
  input  vfu_rsp_t   vfu_rsp_i,
  input  logic       vlsu_rsp_valid_i,
  input  spatz_id_t  vlsu_rsp_id_i,
  output logic       busy_o,
  output logic       err_o
);
  scoreboard_entry_t [NrParallelInstr-1:0] sb_q, sb_d;
  logic hazard, free, can_issue, is_vfu, is_lsu, fire, err_q, err_d;
  spatz_id_t alloc_id;
  spatz_sb_hazard_check i_hazard (
    .req_i   (spatz_req_i),
    .sb_i    (sb_q),
    .hazard_o(hazard),
    .free_o  (free),
    .id_o    (alloc_id)
  );
  assign is_vfu = spatz_req_i.ex_unit == VFU;
  assign is_lsu = spatz_req_i.ex_unit == LSU;
  assign can_issue = spatz_req_valid_i && !hazard && free;
  assign vfu_req_valid_o = can_issue && is_vfu;
  assign vlsu_req_valid_o = can_issue && is_lsu;
  assign fire = is_vfu ? vfu_req_valid_o && vfu_req_ready_i : is_lsu ? vlsu_req_valid_o && vlsu_req_ready_i : can_issue;
  assign spatz_req_ready_o = fire;
  assign err_o = err_q;
  // forward the request with its allocated ID
  always_comb begin
    spatz_req_o = spatz_req_i;
    spatz_req_o.id = alloc_id;
  end
  // busy reflects the registered table only
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < NrParallelInstr; i++) busy_o = busy_o | sb_q[i].valid;
  end
  // retire responses, flag stray IDs, record newly fired VFU/VLSU work
  always_comb begin
    sb_d = sb_q;
    err_d = err_q | (vfu_rsp_valid_i && !sb_q[vfu_rsp_i.id].valid) | (vlsu_rsp_valid_i && !sb_q[vlsu_rsp_id_i].valid);
    if (vfu_rsp_valid_i) sb_d[vfu_rsp_i.id].valid = 1'b0;
    if (vlsu_rsp_valid_i) sb_d[vlsu_rsp_id_i].valid = 1'b0;
    if (fire && (is_vfu || is_lsu)) sb_d[alloc_id] = '{
      valid: 1'b1, vd: spatz_req_i.vd, vs1: spatz_req_i.vs1, vs2: spatz_req_i.vs2,
      use_vd: spatz_req_i.use_vd, use_vs1: spatz_req_i.use_vs1, use_vs2: spatz_req_i.use_vs2,
      vd_is_src: spatz_req_i.vd_is_src, ex_unit: spatz_req_i.ex_unit};
  end
  // table and sticky error state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q <= '0;
      err_q <= 1'b0;
    end else begin
      sb_q <= sb_d;
      err_q <= err_d;
    end
  end
endmodule
